padding_stream: RTL and testbench



---
 rtl/padding_stream_if.sv | 26 ++
 rtl/padding_stream.sv | 163 ++++++++++++++++
 tb/tb_padding_stream.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/padding_stream_if.sv
// Row stream bundle for padding_stream: input row handshake plus padded
// output row handshake with end-of-frame marker.
interface padding_stream_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 48
);
   logic [IN_W-1:0]  in_data;
   logic             in_valid;
   logic             in_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   // block side: consumes input rows, produces padded rows
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last
   );

   // environment side: feeds rows, drains padded rows
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/padding_stream.sv
// padding_stream: adds a PAD-pixel border around a frame that arrives one
// full row (all channels) per beat. Single output register stage with a
// valid/ready handshake; a frame FSM sequences top, body and bottom rows.
// Optional feature macro: PADDING_REPLICATE_EN selects edge replication
// (border pixels copy the nearest edge pixel) instead of zero fill.
module padding_stream #(
   parameter int DW    = 8,
   parameter int IMG_W = 416,
   parameter int IMG_H = 416,
   parameter int PAD   = 1,
   parameter int CH    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   padding_stream_if.slave   st,
   output logic              busy,
   output logic              frame_done
);
   localparam int OW    = IMG_W + 2*PAD;
   localparam int ROWS  = IMG_H + 2*PAD;
   localparam int CW    = $clog2(ROWS + 1);
   localparam int OUT_W = CH*OW*DW;

`ifdef PADDING_REPLICATE_EN
   localparam bit REPL = 1'b1;
`else
   localparam bit REPL = 1'b0;
`endif

   // Replicate mode emits row 0 itself from the hold register as the last
   // TOP row, so TOP covers one more output row than in zero mode.
   localparam logic [CW-1:0] TOP_LAST  = CW'(REPL ? PAD : PAD - 1);
   localparam logic [CW-1:0] BODY_LAST = CW'(PAD + IMG_H - 1);
   localparam logic [CW-1:0] LAST_ROW  = CW'(ROWS - 1);
   localparam logic [CW-1:0] ROWS_C    = CW'(ROWS);

   typedef enum logic [1:0] {IDLE, TOP, BODY, BOTTOM} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;          // output rows loaded into o_reg this frame
   logic [OUT_W-1:0] wide;         // incoming row with its border applied
   logic [OUT_W-1:0] fill;         // row used for top/bottom border rows
   logic             can_load, out_hs;
   logic             rdy, ld, ld_in, done_nxt;

   assign can_load    = !st.out_valid || st.out_ready;
   assign out_hs      = st.out_valid && st.out_ready;
   assign st.in_ready = rdy;
   assign busy        = (state != IDLE);

   // Horizontal padding, independently per channel: middle pixels come
   // straight from the input row, border pixels are zero or edge copies.
   for (genvar c = 0; c < CH; c++) begin : g_ch
      for (genvar x = 0; x < OW; x++) begin : g_px
         if (x >= PAD && x < PAD + IMG_W) begin : g_mid
            assign wide[(c*OW + x)*DW +: DW] = st.in_data[(c*IMG_W + x - PAD)*DW +: DW];
         end else if (!REPL) begin : g_zero
            assign wide[(c*OW + x)*DW +: DW] = '0;
         end else if (x < PAD) begin : g_left
            assign wide[(c*OW + x)*DW +: DW] = st.in_data[c*IMG_W*DW +: DW];
         end else begin : g_right
            assign wide[(c*OW + x)*DW +: DW] = st.in_data[(c*IMG_W + IMG_W - 1)*DW +: DW];
         end
      end
   end

`ifdef PADDING_REPLICATE_EN
   logic [OUT_W-1:0] hold;

   // Keep the most recent widened input row; it backs all replicated
   // top and bottom rows.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     hold <= '0;
      else if (ld_in) hold <= wide;
   end

   assign fill = hold;
`else
   assign fill = '0;
`endif

   // Frame sequencing: decide whether o_reg loads this cycle, from where,
   // and which state follows.
   always_comb begin
      state_nxt = state;
      rdy       = 1'b0;
      ld        = 1'b0;
      ld_in     = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = TOP;
               // Zero mode loads the first top row on the start edge so it
               // shows up the next cycle; with PAD=1 that already completes
               // the top border and the block goes straight to BODY.
               if (!REPL && can_load) begin
                  ld = 1'b1;
                  if (cnt == TOP_LAST) state_nxt = BODY;
               end
            end
         end
         TOP: begin
            if (REPL && cnt == '0) begin
               // waiting for input row 0, which seeds the hold register
               rdy = can_load;
               if (st.in_valid && can_load) begin
                  ld    = 1'b1;
                  ld_in = 1'b1;
               end
            end else if (can_load) begin
               ld = 1'b1;
               if (cnt == TOP_LAST) state_nxt = (REPL && IMG_H == 1) ? BOTTOM : BODY;
            end
         end
         BODY: begin
            rdy = can_load;
            if (st.in_valid && can_load) begin
               ld    = 1'b1;
               ld_in = 1'b1;
               if (cnt == BODY_LAST) state_nxt = BOTTOM;
            end
         end
         BOTTOM: begin
            if (can_load && cnt != ROWS_C) ld = 1'b1;
            if (out_hs && st.out_last) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register, output row counter and end-of-frame pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= done_nxt;
         if (state_nxt == IDLE) cnt <= '0;
         else if (ld)           cnt <= cnt + CW'(1);
      end
   end

   // Output register: refills whenever it is empty or being drained, and
   // otherwise holds data/valid/last frozen under back-pressure.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st.out_valid <= 1'b0;
         st.out_last  <= 1'b0;
         st.out_data  <= '0;
      end else if (can_load) begin
         st.out_valid <= ld;
         st.out_last  <= ld && (cnt == LAST_ROW);
         if (ld) st.out_data <= ld_in ? wide : fill;
      end
   end
endmodule

// File: tb/tb_padding_stream.sv
// Bench for padding_stream: random rows and handshake jitter checked
// against a coordinate-mapping model of the padded frame.
module tb_padding_stream;
   localparam int DW    = 8;
   localparam int IMG_W = 4;
   localparam int IMG_H = 3;
   localparam int PAD   = 2;
   localparam int CH    = 2;
   localparam int OW    = IMG_W + 2*PAD;
   localparam int ROWS  = IMG_H + 2*PAD;
   localparam int IN_W  = CH*IMG_W*DW;
   localparam int OUT_W = CH*OW*DW;

`ifdef PADDING_REPLICATE_EN
   localparam bit REPL = 1'b1;
   localparam logic [OUT_W-1:0] K_TOP = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0404_0403_0201_0101};
   localparam logic [OUT_W-1:0] K_MID = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0808_0807_0605_0505};
`else
   localparam bit REPL = 1'b0;
   localparam logic [OUT_W-1:0] K_TOP = '0;
   localparam logic [OUT_W-1:0] K_MID = {64'h0000_FFFF_FFFF_0000, 64'h0000_0807_0605_0000};
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic busy, frame_done;
   int   nvec = 0;
   int   nerr = 0;

   padding_stream_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   padding_stream #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .PAD(PAD), .CH(CH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .st        (bus),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   task automatic run_frame(input int in_pct, input int rdy_pct, input bit noise, input bit fixed,
                            input bit force_bp, input bit pre, input bit chain, input int rst_at);
      logic [IN_W-1:0]  rows [IMG_H];
      logic [OUT_W-1:0] exp_q [ROWS];
      logic [OUT_W-1:0] prev;
      int oi, ii, cyc, bp_left, y, xx, fin, fout;
      bit bp, z;
      oi = 0; ii = 0; cyc = 0; bp_left = 3; bp = 1'b0; prev = '0; fin = -1; fout = -1;

      for (int r = 0; r < IMG_H; r++) begin
         rows[r] = {$urandom, $urandom};
         if (fixed) begin
            for (int x = 0; x < IMG_W; x++) begin
               rows[r][x*DW +: DW]         = 8'(4*r + x + 1);
               rows[r][(IMG_W+x)*DW +: DW] = 8'hFF;
            end
         end
      end

      // each output pixel maps back to a source pixel (clamped) or to zero
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < CH; c++)
            for (int x = 0; x < OW; x++) begin
               y = r - PAD; xx = x - PAD; z = 1'b0;
               if (REPL) begin
                  y  = (y < 0)  ? 0 : (y >= IMG_H)  ? IMG_H - 1 : y;
                  xx = (xx < 0) ? 0 : (xx >= IMG_W) ? IMG_W - 1 : xx;
               end else begin
                  z = (y < 0 || y >= IMG_H || xx < 0 || xx >= IMG_W);
               end
               if (z) exp_q[r][(c*OW + x)*DW +: DW] = '0;
               else   exp_q[r][(c*OW + x)*DW +: DW] = rows[y][(c*IMG_W + xx)*DW +: DW];
            end

      if (!pre) begin
         repeat (noise ? 3 : 1) begin
            @(negedge clk);
            start = 1'b0;
            bus.in_valid  = noise;
            bus.in_data   = {$urandom, $urandom};
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("idle_busy",  OUT_W'(busy), '0);
            chk("idle_ready", OUT_W'(bus.in_ready), '0);
            chk("idle_valid", OUT_W'(bus.out_valid), '0);
            chk("done_pulse", OUT_W'(frame_done), '0);
         end
         @(negedge clk);
         start = 1'b1;
         bus.in_valid = 1'b0;
      end

      while (oi < ROWS && cyc < 300) begin
         @(negedge clk);
         cyc++;
         start = noise && ($urandom_range(0, 3) == 0);
         bus.out_ready = ($urandom_range(1, 100) <= rdy_pct);
         if (force_bp && bus.out_valid && oi == PAD + 1 && bp_left > 0) begin
            bus.out_ready = 1'b0;
            bp_left--;
         end
         bus.in_valid = (ii < IMG_H) ? ($urandom_range(1, 100) <= in_pct)
                                     : (noise && $urandom_range(0, 1) == 1);
         bus.in_data  = (ii < IMG_H) ? rows[ii] : IN_W'({$urandom, $urandom});
         #1;
         chk("done_mid", OUT_W'(frame_done), '0);
         chk("busy_mid", OUT_W'(busy), OUT_W'(1));
         if (cyc == 1) chk("first_valid", OUT_W'(bus.out_valid), OUT_W'(!REPL));
         if (bp) begin
            chk("bp_valid", OUT_W'(bus.out_valid), OUT_W'(1));
            chk("bp_data", bus.out_data, prev);
         end
         if (bus.out_valid && !bus.out_ready) chk("bp_in_ready", OUT_W'(bus.in_ready), '0);
         bp   = bus.out_valid && !bus.out_ready;
         prev = bus.out_data;
         if (bus.in_valid && bus.in_ready) begin
            if (fin < 0) fin = cyc;
            ii++;
         end
         if (bus.out_valid && fout < 0) begin
            fout = cyc;
            if (REPL) chk("repl_latency", OUT_W'(fout - fin), OUT_W'(1));
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("row", bus.out_data, exp_q[oi]);
            chk("last", OUT_W'(bus.out_last), OUT_W'(oi == ROWS - 1));
            if (fixed && oi == 0)       chk("k_top", bus.out_data, K_TOP);
            if (fixed && oi == PAD + 1) chk("k_mid", bus.out_data, K_MID);
            oi++;
         end
         if (rst_at >= 0 && oi == rst_at) begin
            reset = 1'b0;
            #1;
            chk("rst_valid", OUT_W'(bus.out_valid), '0);
            chk("rst_busy",  OUT_W'(busy), '0);
            chk("rst_data",  bus.out_data, '0);
            chk("rst_last",  OUT_W'(bus.out_last), '0);
            chk("rst_ready", OUT_W'(bus.in_ready), '0);
            @(negedge clk);
            reset = 1'b1;
            start = 1'b0;
            bus.in_valid = 1'b0;
            return;
         end
      end

      if (oi < ROWS) begin
         chk("timeout_rows", OUT_W'(oi), OUT_W'(ROWS));
         reset = 1'b0;
         @(negedge clk);
         reset = 1'b1;
         return;
      end
      if (in_pct == 100 && rdy_pct == 100 && !force_bp)
         chk("frame_cycles", OUT_W'(cyc), OUT_W'(REPL ? ROWS + 1 : ROWS));

      @(negedge clk);
      start = chain;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("frame_done", OUT_W'(frame_done), OUT_W'(1));
      chk("busy_end",   OUT_W'(busy), '0);
      chk("valid_end",  OUT_W'(bus.out_valid), '0);
      chk("rows_taken", OUT_W'(ii), OUT_W'(IMG_H));
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_valid", OUT_W'(bus.out_valid), '0);
      chk("reset_data",  bus.out_data, '0);
      chk("reset_last",  OUT_W'(bus.out_last), '0);
      chk("reset_busy",  OUT_W'(busy), '0);
      chk("reset_done",  OUT_W'(frame_done), '0);
      chk("reset_ready", OUT_W'(bus.in_ready), '0);
      @(negedge clk);
      reset = 1'b1;

      run_frame(100, 100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);  // known rows, full rate
      run_frame(100, 100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);  // known rows, 3-cycle stall
      repeat (4) run_frame(70, 60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);  // spurious start/valid
      run_frame(100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);   // reset after two rows
      run_frame(100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);  // start on frame_done cycle
      run_frame(100, 100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);  // back-to-back frame
      repeat (3) run_frame(50, 50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end
endmodule
